// File: rtl/mesm6_bitops_pkg.sv
// Shared types and helpers for the MESM-6 multi-cycle bit-manipulation unit.
package mesm6_bitops_pkg;

    typedef enum logic [2:0] {
        NOP    = 3'd0,
        SHIFT  = 3'd1,
        ROTATE = 3'd2,
        PACK   = 3'd3,
        UNPACK = 3'd4,
        COUNT  = 3'd5,
        CLZ    = 3'd6
    } bitops_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        CARRY  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Distance moved on one RUN edge: what is left, capped at the per-cycle step.
    function automatic int unsigned step_dist(input int unsigned remaining,
                                              input int unsigned step);
        return (remaining < step) ? remaining : step;
    endfunction

endpackage

// File: rtl/mesm6_bitops_clz.sv
// Leading-zero count plus one (0 for an all-zero word); purely combinational.
module mesm6_bitops_clz #(
    parameter int unsigned WIDTH = 48
) (
    input  logic [WIDTH-1:0]              vec_i,
    output logic [$clog2(WIDTH+1)-1:0]    lz1_c
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    // Highest set bit wins because it is visited last.
    always_comb begin
        lz1_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) lz1_c = CW'(WIDTH - 32'(i));
        end
    end

endmodule

// File: rtl/mesm6_bitops.sv
// MESM-6 bit-manipulation unit: shift, rotate, pack, unpack, popcount and CLZ
// with a start/busy/done handshake and abort.
module mesm6_bitops
    import mesm6_bitops_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned STEP  = 4,
    parameter int unsigned SW    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  bitops_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SW-1:0]    shamt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] y
);
    localparam int unsigned AW = $clog2(WIDTH);
    localparam int unsigned CW = (SW > AW) ? SW : AW;
    localparam int unsigned PW = $clog2(WIDTH + 1);
    localparam int unsigned W1 = WIDTH + 1;

    state_t           state_q, state_d;
    bitops_op_t       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] msk_q, msk_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;   // 1 = right
    logic             cy_q, cy_d;

    logic [SW-1:0]      mag_c;
    logic [CW-1:0]      rot_c;
    logic [CW-1:0]      dist_c;
    logic [PW-1:0]      pop_c;
    logic [PW-1:0]      clz_c;
    logic [W1-1:0]      cnt_sum_c;
    logic [W1-1:0]      clz_sum_c;
    logic [WIDTH-1:0]   msk_next_c;
    logic [2*WIDTH-1:0] wide_c;

    mesm6_bitops_clz #(.WIDTH(WIDTH)) u_clz (
        .vec_i (a),
        .lz1_c (clz_c)
    );

    assign mag_c      = shamt[SW-1] ? -shamt : shamt;
    assign rot_c      = CW'(32'(mag_c) % WIDTH);
    assign dist_c     = CW'(step_dist(32'(rem_q), STEP));
    assign msk_next_c = msk_q >> 1;
    assign cnt_sum_c  = W1'(pop_c) + W1'(b);
    assign clz_sum_c  = W1'(clz_c) + W1'(b);

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < WIDTH; i++) pop_c = pop_c + PW'(a[i]);
    end

    // Next-state and datapath; acc/y double as the working registers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        y_d     = y_q;
        src_d   = src_q;
        msk_d   = msk_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        cy_d    = cy_q;
        wide_c  = '0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    y_d     = '0;
                    src_d   = a;
                    msk_d   = b;
                    idx_d   = '0;
                    pos_d   = '0;
                    rem_d   = '0;
                    cy_d    = 1'b0;
                    dir_d   = ~shamt[SW-1];
                    state_d = FINISH;
                    case (op)
                        SHIFT: begin
                            op_d  = SHIFT;
                            acc_d = a;
                            rem_d = CW'(mag_c);
                            if (mag_c != '0) state_d = RUN;
                        end
                        ROTATE: begin
                            op_d  = ROTATE;
                            acc_d = a;
                            rem_d = rot_c;
                            if (rot_c != '0) state_d = RUN;
                        end
                        PACK, UNPACK: begin
                            op_d = op;
                            if (b != '0) state_d = RUN;
                        end
                        COUNT: begin
                            op_d          = COUNT;
                            {cy_d, acc_d} = cnt_sum_c;
                            state_d       = CARRY;
                        end
                        CLZ: begin
                            op_d          = CLZ;
                            {cy_d, acc_d} = clz_sum_c;
                            y_d           = a << clz_c;
                            state_d       = CARRY;
                        end
                        default: begin
                            op_d  = NOP;
                            acc_d = a;
                            y_d   = a;
                        end
                    endcase
                end
            end

            RUN: begin
                case (op_q)
                    SHIFT: begin
                        if (dir_q) {acc_d, y_d} = {acc_q, y_q} >> dist_c;
                        else       {y_d, acc_d} = {y_q, acc_q} << dist_c;
                        rem_d = rem_q - dist_c;
                        if (rem_q == dist_c) state_d = FINISH;
                    end
                    ROTATE: begin
                        if (dir_q) begin
                            wide_c = {acc_q, acc_q} >> dist_c;
                            acc_d  = wide_c[WIDTH-1:0];
                        end else begin
                            wide_c = {acc_q, acc_q} << dist_c;
                            acc_d  = wide_c[2*WIDTH-1:WIDTH];
                        end
                        rem_d = rem_q - dist_c;
                        if (rem_q == dist_c) state_d = FINISH;
                    end
                    PACK: begin
                        if (msk_q[0]) begin
                            acc_d[idx_q] = src_q[0];
                            idx_d        = idx_q + AW'(1);
                        end
                        src_d = src_q >> 1;
                        msk_d = msk_next_c;
                        pos_d = pos_q + AW'(1);
                        if (msk_next_c == '0) state_d = FINISH;
                    end
                    UNPACK: begin
                        if (msk_q[0]) begin
                            acc_d[pos_q] = src_q[0];
                            src_d        = src_q >> 1;
                        end
                        msk_d = msk_next_c;
                        pos_d = pos_q + AW'(1);
                        if (msk_next_c == '0) state_d = FINISH;
                    end
                    default: state_d = FINISH;
                endcase
            end

            // End-around carry of the COUNT/CLZ sum.
            CARRY: begin
                acc_d   = acc_q + WIDTH'(cy_q);
                cy_d    = 1'b0;
                state_d = FINISH;
            end

            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            acc_d   = '0;
            y_d     = '0;
            cy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            src_q   <= '0;
            msk_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            src_q   <= src_d;
            msk_q   <= msk_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            cy_q    <= cy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign acc  = acc_q;
    assign y    = y_q;

endmodule

// File: tb/tb_mesm6_bitops.sv
// Directed self-checking bench for mesm6_bitops (WIDTH=48, STEP=4, SW=7).
module tb_mesm6_bitops;
    import mesm6_bitops_pkg::*;

    localparam int unsigned WIDTH = 48;
    localparam int unsigned STEP  = 4;
    localparam int unsigned SW    = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    bitops_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SW-1:0]    shamt;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] y;

    int checks   = 0;
    int failures = 0;

    mesm6_bitops #(.WIDTH(WIDTH), .STEP(STEP), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .shamt (shamt),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .acc   (acc),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation, measure edges to done, check results and the one-cycle pulse.
    task automatic run_op(input string tag, input bitops_op_t o,
                          input logic [47:0] av, input logic [47:0] bv, input logic [6:0] sh,
                          input int exp_n, input logic [47:0] exp_acc, input logic [47:0] exp_y);
        int n;
        op = o; a = av; b = bv; shamt = sh; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 300);
        check({tag, "_lat"},      64'(n),       64'(exp_n));
        check({tag, "_busy_off"}, 64'(busy),    64'd0);
        check({tag, "_acc"},      64'(acc),     64'(exp_acc));
        check({tag, "_y"},        64'(y),       64'(exp_y));
        tick();
        check({tag, "_pulse"},    64'(done),    64'd0);
        check({tag, "_hold"},     64'(acc),     64'(exp_acc));
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; op = NOP;
        a = '0; b = '0; shamt = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_acc",  64'(acc),  64'd0);
        check("rst_y",    64'(y),    64'd0);
        tick();
        reset = 1'b0;
        tick();

        run_op("shr5",  SHIFT,  48'h800000000001, 48'h0, 7'h05, 3,  48'h040000000000, 48'h080000000000);
        run_op("shl3",  SHIFT,  48'hE00000000001, 48'h0, 7'h7D, 2,  48'h000000000008, 48'h7);
        run_op("shr63", SHIFT,  48'hFFFFFFFFFFFF, 48'h0, 7'h3F, 17, 48'h0, 48'h0001FFFFFFFF);
        run_op("shl64", SHIFT,  48'hFFFFFFFFFFFF, 48'h0, 7'h40, 17, 48'h0, 48'hFFFFFFFF0000);
        run_op("sh0",   SHIFT,  48'h123456789ABC, 48'h0, 7'h00, 1,  48'h123456789ABC, 48'h0);
        run_op("rotr1", ROTATE, 48'h000000000001, 48'h0, 7'h01, 2,  48'h800000000000, 48'h0);
        run_op("rotl50",ROTATE, 48'h000000000001, 48'h0, 7'h4E, 2,  48'h000000000004, 48'h0);
        run_op("rot48", ROTATE, 48'h00000000ABCD, 48'h0, 7'h30, 1,  48'h00000000ABCD, 48'h0);
        run_op("pack",  PACK,   48'h0000000000A5, 48'hF0, 7'h0, 9, 48'hA, 48'h0);
        run_op("unpk",  UNPACK, 48'h000000000003, 48'hF0, 7'h0, 9, 48'h30, 48'h0);
        run_op("pack0", PACK,   48'h0000000000A5, 48'h0,  7'h0, 1, 48'h0, 48'h0);
        run_op("cnt",   COUNT,  48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 7'h0, 2, 48'h30, 48'h0);
        run_op("clz",   CLZ,    48'h000100000000, 48'h0, 7'h0, 2, 48'h10, 48'h0);
        run_op("clzeac",CLZ,    48'h000000000F00, 48'hFFFFFFFFFFFF, 7'h0, 2, 48'h25, 48'hE00000000000);
        run_op("nop",   NOP,    48'h123456789ABC, 48'h0, 7'h0, 1, 48'h123456789ABC, 48'h123456789ABC);
        run_op("op7",   bitops_op_t'(3'd7), 48'h0000DEADBEEF, 48'h5, 7'h3, 1,
               48'h0000DEADBEEF, 48'h0000DEADBEEF);

        // Ignored restart, then abort of a long shift.
        op = SHIFT; a = 48'hFFFF00000000; b = '0; shamt = 7'h28; start = 1'b1;
        tick();
        start = 1'b0;
        check("abt_busy0", 64'(busy), 64'd1);
        tick();
        tick();
        op = NOP; a = 48'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        check("abt_ign_busy", 64'(busy), 64'd1);
        check("abt_ign_done", 64'(done), 64'd0);
        tick();
        tick();
        check("abt_busy5", 64'(busy), 64'd1);
        check("abt_done5", 64'(done), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_busy6", 64'(busy), 64'd0);
        check("abt_done6", 64'(done), 64'd0);
        check("abt_acc",   64'(acc),  64'd0);
        check("abt_y",     64'(y),    64'd0);
        expect_quiet("abt_quiet", 12);
        run_op("post_abt", SHIFT, 48'h000000000100, 48'h0, 7'h04, 2, 48'h000000000010, 48'h0);

        // Asynchronous reset in the middle of a PACK.
        op = PACK; a = 48'hFF; b = 48'hFF; shamt = '0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rp_acc_mid", 64'(acc), 64'h7);
        #2;
        reset = 1'b1;
        #1;
        check("rp_busy", 64'(busy), 64'd0);
        check("rp_done", 64'(done), 64'd0);
        check("rp_acc",  64'(acc),  64'd0);
        check("rp_y",    64'(y),    64'd0);
        tick();
        reset = 1'b0;
        expect_quiet("rp_quiet", 12);
        check("rp_busy_after", 64'(busy), 64'd0);

        // Start and abort together in IDLE: start dropped, results held.
        run_op("pre_sa", NOP, 48'h000000000ABC, 48'h0, 7'h0, 1, 48'h000000000ABC, 48'h000000000ABC);
        op = NOP; a = 48'h000000000DEF; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 64'(busy), 64'd0);
        check("sa_acc",  64'(acc),  64'h000000000ABC);
        expect_quiet("sa_quiet", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mesm6_bitops.md
Name: mesm6_bitops

Overview:
Parametrised multi-cycle bit-manipulation unit for the MESM-6 core. It covers the shift, rotate, pack, unpack, popcount and leading-zero operations of the arithmetic unit, with configurable word width and shift step. It adds an explicit start/busy/done handshake, abort and asynchronous reset. It sits beside the floating-point ALU and shares its A/B operand buses and its Y (low-word) result convention.

Parameters:
WIDTH, 48, operand/result width in bits (>= 8).
STEP, 4, maximum shift/rotate distance per cycle; power of 2, 1..WIDTH.
SW, 7, width of the signed shift-amount input.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  operation request; sampled only when idle
op  in  3  operation code (package enum)
a  in  WIDTH  operand A (data)
b  in  WIDTH  operand B (mask or addend)
shamt  in  SW  signed shift/rotate amount; positive = right
abort  in  1  cancel current operation
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle completion pulse
acc  out  WIDTH  primary result
y  out  WIDTH  secondary (Y register) result

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, done=0, acc=0, y=0, state IDLE.
- States: IDLE, RUN, CARRY, FINISH.
- Start is accepted in IDLE (edge 0): operands are latched and busy=1. The done pulse follows N edges later, and busy drops on the same edge. acc and y hold until the next accepted start.
- Start while busy: ignored.
- Abort while busy: next edge returns to IDLE with busy=0, acc=0, y=0 and no done pulse.
- Abort in the same cycle as a start in IDLE: abort wins and the start is dropped.
- NOP: acc=a, y=a; N=1.
- SHIFT, k=|shamt|:
  - Right: {acc,y} = {a,0} >> k.
  - Left: {y,acc} = {0,a} << k.
  - Each RUN edge moves min(STEP, remaining) bits. N = ceil(k/STEP)+1; k=0 gives N=1.
  - k >= 2*WIDTH yields all zeros.
- ROTATE: r = |shamt| mod WIDTH; acc = a rotated right (shamt>0) or left (shamt<0) by r; y=0. N = ceil(r/STEP)+1.
- PACK (bit extract):
  - Bits of a at set positions of mask b are gathered into the acc LSBs, order preserved; upper bits are 0; y=0.
  - One mask bit per RUN edge, LSB first, with early exit when the remaining mask is 0.
  - N = m+1, where m = (index of highest set bit of b)+1; b=0 gives N=1.
- UNPACK (bit deposit): the LSBs of a are placed at the set positions of b in order; other acc bits are 0; y=0. Same N as PACK.
- COUNT: sum = popcount(a) + b, computed (WIDTH+1) bits wide. The CARRY edge adds the carry back in (end-around); acc = result, y=0. N=2.
- CLZ:
  - c = (leading zeros of a) + 1, or 0 if a == 0.
  - acc = end-around-carry sum of c and b; y = a << c (mod WIDTH). N=2.
- Unknown op codes are treated as NOP.

Decomposition:
- Package mesm6_bitops_pkg holds:
  - enum bitops_op_t: NOP=0, SHIFT=1, ROTATE=2, PACK=3, UNPACK=4, COUNT=5, CLZ=6.
  - state enum.
  - a function for the STEP-bounded distance.
- Sub-module mesm6_bitops_clz (combinational leading-zero+1 counter, parametrised by WIDTH).
- The rest is in one module.

Test Plan:
All cases use WIDTH=48, STEP=4.
- SHIFT a=48'h800000000001, shamt=+5 -> acc=48'h040000000000, y=48'h080000000000, done 3 edges after start.
- SHIFT a=48'hE00000000001, shamt=-3 -> acc=48'h000000000008, y=48'h7, N=2. ROTATE a=1, shamt=+1 -> acc=48'h800000000000, y=0, N=2.
- PACK a=48'hA5, b=48'hF0 -> acc=48'hA, y=0, N=9. UNPACK a=48'h3, b=48'hF0 -> acc=48'h30, N=9. b=0 -> acc=0, N=1.
- COUNT a=b=48'hFFFFFFFFFFFF -> acc=48'h30 (end-around carry applied), N=2. CLZ a=48'h000100000000, b=0 -> acc=16, y=0.
- SHIFT shamt=+40 (N=11); second start at edge 3 is ignored; abort at edge 5 -> no done, busy=0 at edge 6, acc=y=0. Next start is accepted normally.
- Reset asserted asynchronously mid-PACK -> outputs zero immediately, with no done. Start and abort in the same IDLE cycle -> busy stays 0.
